// File: rtl/neuron_feeder.sv
`default_nettype none
//============================================================================
// Module      : neuron_feeder
// Description : Sequencer for a 16-lane neuron. It clears the neuron, streams
//               N chunks of pixel/weight pairs onto the lanes, waits out the
//               neuron pipeline latency, then captures the 26-bit dot product
//               and offers it downstream with a valid/ready handshake.
// Revision    : 1.0 - initial release
//============================================================================

`ifndef PIX_WIDTH
`define PIX_WIDTH 8
`endif
`ifndef WGT_WIDTH
`define WGT_WIDTH 8
`endif

module neuron_feeder #(
    parameter int PIX_W    = `PIX_WIDTH,
    parameter int WGT_W    = `WGT_WIDTH,
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = 6
) (
    input  logic                Clk,
    input  logic                GlobalReset,
    input  logic                Start,
    input  logic [CNT_W-1:0]    Num_Chunks,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic [16*PIX_W-1:0] In_Pixels,
    input  logic [16*WGT_W-1:0] In_Weights,
    output logic [16*PIX_W-1:0] Lane_Pixels,
    output logic [16*WGT_W-1:0] Lane_Weights,
    output logic                Neuron_Clear,
    input  logic [25:0]         Neuron_Out,
    output logic [25:0]         Result,
    output logic                Result_Valid,
    input  logic                Result_Ready,
    output logic                Busy
);

    // Drain counter must hold the value PIPE_LAT; keep at least one bit.
    localparam int c_DRN_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_count;
    logic [c_DRN_W-1:0]   r_drain;
    logic [16*PIX_W-1:0]  r_lane_pix;
    logic [16*WGT_W-1:0]  r_lane_wgt;
    logic [25:0]          r_result;
    logic                 r_result_valid;
    logic                 w_in_ready;
    logic                 w_xfer;
    logic                 w_drain_done;

    // Ready depends only on state and remaining count so the source can
    // rely on it without a combinational loop through In_Valid.
    assign w_in_ready   = (r_state == S_FEED) && (r_count != '0);
    assign w_xfer       = w_in_ready && In_Valid;
    assign w_drain_done = (r_state == S_DRAIN) && (r_drain == '0);

    assign In_Ready     = w_in_ready;
    assign Neuron_Clear = (r_state == S_CLEAR);
    assign Busy         = (r_state != S_IDLE);
    assign Lane_Pixels  = r_lane_pix;
    assign Lane_Weights = r_lane_wgt;
    assign Result       = r_result;
    assign Result_Valid = r_result_valid;

    // State register.
    always_ff @(posedge Clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; Start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = (r_count == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                if (w_xfer && (r_count == CNT_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (Result_Ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Lane registers: a transferred chunk sits on the lanes for exactly one
    // cycle; every other cycle the lanes carry zeros so the neuron adds 0.
    always_ff @(posedge Clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_lane_pix <= '0;
            r_lane_wgt <= '0;
        end else if (w_xfer) begin
            r_lane_pix <= In_Pixels;
            r_lane_wgt <= In_Weights;
        end else begin
            r_lane_pix <= '0;
            r_lane_wgt <= '0;
        end
    end

    // Remaining-chunk counter: loaded on an accepted Start, decremented per
    // transfer. It only decrements while non-zero, so it cannot wrap.
    always_ff @(posedge Clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_count <= '0;
        end else if ((r_state == S_IDLE) && Start) begin
            r_count <= Num_Chunks;
        end else if (w_xfer) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Drain counter: loaded on DRAIN entry, i.e. the edge that puts the last
    // chunk on the lanes (or CLEAR exit for an empty run); the capture edge
    // follows once it has counted down PIPE_LAT further edges.
    always_ff @(posedge Clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_drain <= '0;
        end else if ((w_state_nxt == S_DRAIN) && (r_state != S_DRAIN)) begin
            r_drain <= c_DRN_W'(PIPE_LAT);
        end else if ((r_state == S_DRAIN) && (r_drain != '0)) begin
            r_drain <= r_drain - c_DRN_W'(1);
        end
    end

    // Result capture and output handshake; Result keeps its value after
    // being accepted, only the valid flag drops.
    always_ff @(posedge Clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else if (w_drain_done) begin
            r_result       <= Neuron_Out;
            r_result_valid <= 1'b1;
        end else if ((r_state == S_DONE) && Result_Ready) begin
            r_result_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_neuron_feeder.sv
`default_nettype none
//============================================================================
// Module      : tb_neuron_feeder
// Description : Directed self-checking bench for neuron_feeder with a
//               behavioural 16-lane neuron (6-cycle latency) attached.
// Revision    : 1.0 - initial release
//============================================================================

module tb_neuron_feeder;

    localparam int PW = 8;
    localparam int WW = 8;

    logic              Clk = 1'b0;
    logic              GlobalReset = 1'b0;
    logic              Start = 1'b0;
    logic [7:0]        Num_Chunks = '0;
    logic              In_Valid = 1'b0;
    logic              In_Ready;
    logic [16*PW-1:0]  In_Pixels = '0;
    logic [16*WW-1:0]  In_Weights = '0;
    logic [16*PW-1:0]  Lane_Pixels;
    logic [16*WW-1:0]  Lane_Weights;
    logic              Neuron_Clear;
    logic [25:0]       Neuron_Out;
    logic [25:0]       Result;
    logic              Result_Valid;
    logic              Result_Ready = 1'b0;
    logic              Busy;

    int checks   = 0;
    int failures = 0;
    int ready_cnt;

    neuron_feeder #(
        .PIX_W    (PW),
        .WGT_W    (WW),
        .CNT_W    (8),
        .PIPE_LAT (6)
    ) dut (
        .Clk          (Clk),
        .GlobalReset  (GlobalReset),
        .Start        (Start),
        .Num_Chunks   (Num_Chunks),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .In_Pixels    (In_Pixels),
        .In_Weights   (In_Weights),
        .Lane_Pixels  (Lane_Pixels),
        .Lane_Weights (Lane_Weights),
        .Neuron_Clear (Neuron_Clear),
        .Neuron_Out   (Neuron_Out),
        .Result       (Result),
        .Result_Valid (Result_Valid),
        .Result_Ready (Result_Ready),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    // Behavioural neuron: 1 multiply stage, 4 tree stages, 1 accumulate.
    logic [25:0] m_p0 = '0, m_p1 = '0, m_p2 = '0, m_p3 = '0, m_p4 = '0;
    logic [25:0] m_acc = '0;
    logic [25:0] m_sum;

    always_comb begin
        m_sum = '0;
        for (int i = 0; i < 16; i++) begin
            m_sum = m_sum + 26'(Lane_Pixels[i*PW +: PW]) * 26'(Lane_Weights[i*WW +: WW]);
        end
    end

    always @(posedge Clk) begin
        if (Neuron_Clear) begin
            m_p0 <= '0; m_p1 <= '0; m_p2 <= '0; m_p3 <= '0; m_p4 <= '0;
            m_acc <= '0;
        end else begin
            m_p0 <= m_sum; m_p1 <= m_p0; m_p2 <= m_p1; m_p3 <= m_p2; m_p4 <= m_p3;
            m_acc <= m_acc + m_p4;
        end
    end
    assign Neuron_Out = m_acc;

    function automatic logic [127:0] rep8(input int v);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(v);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue Start and confirm the one-cycle clear pulse follows it.
    task automatic start_run(input int num);
        Start = 1'b1;
        Num_Chunks = 8'(num);
        step();
        Start = 1'b0;
        chk("clear_pulse", 128'(Neuron_Clear), 128'(1));
        chk("busy_clear", 128'(Busy), 128'(1));
    endtask

    // Feed chunks from the CLEAR cycle onward until stop_at transfers.
    // Chunk k carries pixels pix0+k*pstep and weights wgt.
    // bubble=1 presents In_Valid only on every third cycle.
    task automatic feed(input int stop_at, input int bubble,
                        input int pix0, input int pstep, input int wgt);
        int k;
        int cyc;
        bit xf;
        k = 0;
        cyc = 0;
        ready_cnt = 0;
        while (k < stop_at && cyc < 60) begin
            In_Valid   = bubble ? ((cyc % 3) == 0) : 1'b1;
            In_Pixels  = rep8(pix0 + k * pstep);
            In_Weights = rep8(wgt);
            if (In_Ready) ready_cnt++;
            xf = In_Valid && In_Ready;
            step();
            if (cyc == 0) chk("clear_one_cycle", 128'(Neuron_Clear), 128'(0));
            if (xf) begin
                chk("lane_pix", 128'(Lane_Pixels), rep8(pix0 + k * pstep));
                chk("lane_wgt", 128'(Lane_Weights), rep8(wgt));
                k++;
            end else begin
                chk("lane_bubble", 128'(Lane_Pixels), 128'(0));
            end
            cyc++;
        end
        In_Valid = 1'b0;
        chk("feed_transfers", 128'(k), 128'(stop_at));
    endtask

    // Count edges until Result_Valid rises; expects lat edges.
    task automatic wait_result(input int lat, input logic [25:0] exp_res);
        int n;
        int rdy;
        n = 0;
        rdy = 0;
        while (!Result_Valid && n < 20) begin
            if (In_Ready) rdy++;
            step();
            n++;
        end
        chk("result_latency", 128'(n), 128'(lat));
        chk("ready_in_drain", 128'(rdy), 128'(0));
        chk("result_value", 128'(Result), 128'(exp_res));
    endtask

    task automatic accept(input logic [25:0] exp_res);
        Result_Ready = 1'b1;
        step();
        Result_Ready = 1'b0;
        chk("valid_drop", 128'(Result_Valid), 128'(0));
        chk("idle_after_accept", 128'(Busy), 128'(0));
        chk("result_kept", 128'(Result), 128'(exp_res));
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_busy", 128'(Busy), 128'(0));
        chk("rst_ready", 128'(In_Ready), 128'(0));
        chk("rst_clear", 128'(Neuron_Clear), 128'(0));
        chk("rst_result", 128'(Result), 128'(0));
        chk("rst_valid", 128'(Result_Valid), 128'(0));
        chk("rst_lanes", 128'(Lane_Pixels), 128'(0));
        GlobalReset = 1'b1;
        step();

        // Single chunk: 16 * 1 * 2 = 32
        start_run(1);
        feed(1, 0, 1, 0, 2);
        chk("single_ready_cnt", 128'(ready_cnt), 128'(1));
        wait_result(7, 26'd32);
        accept(26'd32);

        // Back-to-back four chunks: 16*(1+2+3+4) = 160
        start_run(4);
        feed(4, 0, 1, 1, 1);
        chk("b2b_ready_cnt", 128'(ready_cnt), 128'(4));
        wait_result(7, 26'd160);
        accept(26'd160);

        // Same four chunks with bubbles in In_Valid
        start_run(4);
        feed(4, 1, 1, 1, 1);
        wait_result(7, 26'd160);
        accept(26'd160);

        // Zero chunks: CLEAR goes straight to DRAIN, result is 0
        start_run(0);
        chk("zero_ready", 128'(In_Ready), 128'(0));
        step();
        wait_result(7, 26'd0);
        accept(26'd0);

        // Backpressure: 16 * 2 * 3 = 96 held while Result_Ready stays low
        start_run(1);
        feed(1, 0, 2, 0, 3);
        wait_result(7, 26'd96);
        for (int i = 0; i < 10; i++) begin
            Start = (i % 2) == 0;
            Num_Chunks = 8'd5;
            step();
            chk("bp_result", 128'(Result), 128'(96));
            chk("bp_valid", 128'(Result_Valid), 128'(1));
            chk("bp_busy", 128'(Busy), 128'(1));
        end
        // Start coincident with acceptance must be ignored
        Start = 1'b1;
        Result_Ready = 1'b1;
        step();
        Start = 1'b0;
        Result_Ready = 1'b0;
        chk("bp_release_valid", 128'(Result_Valid), 128'(0));
        chk("bp_start_ignored", 128'(Busy), 128'(0));
        step();
        chk("bp_still_idle", 128'(Busy), 128'(0));

        // Reset in the middle of FEED after two of four chunks
        start_run(4);
        feed(2, 0, 5, 1, 7);
        GlobalReset = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(Busy), 128'(0));
        chk("mid_rst_lanes", 128'(Lane_Pixels), 128'(0));
        chk("mid_rst_wlanes", 128'(Lane_Weights), 128'(0));
        chk("mid_rst_ready", 128'(In_Ready), 128'(0));
        chk("mid_rst_result", 128'(Result), 128'(0));
        chk("mid_rst_valid", 128'(Result_Valid), 128'(0));
        step();
        GlobalReset = 1'b1;
        step();

        // Fresh run after abort: 16 * 3 * 3 = 144, no residue
        start_run(1);
        feed(1, 0, 3, 0, 3);
        wait_result(7, 26'd144);
        accept(26'd144);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
